serial_sweep_sequencer: RTL and testbench

Controller for the memory-to-serial-link transfer path. On a start request it sweeps every address of a 16×4 synchronous memory, fetches each word, and sends one 8-bit frame per address ({addr, data}, MSB first) on the 3-wire link (`tx_clk`, `tx_sync`, `tx_data`) consumed by the remote receiver. It owns address sequencing, memory read timing, bit timing and start/finish handshaking.

---
 rtl/serial_sweep_sequencer.sv | 144 ++++++++++++++
 tb/tb_serial_sweep_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sweep_sequencer.sv
// Sweeps a 16x4 synchronous memory and sends one {addr, data} frame per
// address, MSB first, over a tx_clk/tx_sync/tx_data serial link.
module serial_sweep_sequencer #(
  parameter int unsigned CLK_DIV   = 2,
  parameter logic [3:0]  LAST_ADDR = 4'd15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  output logic [3:0] mem_addr,
  input  logic [3:0] mem_data,
  output logic       busy,
  output logic       done,
  output logic       tx_clk,
  output logic       tx_sync,
  output logic       tx_data
);

  localparam int unsigned  PW     = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] P_HIGH = PW'(CLK_DIV);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SHIFT,
    GAP,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ph_q, ph_d;
  logic [2:0]      bit_q, bit_d;
  logic [3:0]      addr_d;
  logic [7:0]      sr_q, sr_d;
  logic            ena_q;
  logic            start;

  logic            busy_d, done_d, tx_clk_d, tx_sync_d, tx_data_d;

  // ena history resets to 1 so a level held through reset is not an edge
  assign start = ena & ~ena_q;

  // State, counters, address and shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ph_q     <= '0;
      bit_q    <= '0;
      mem_addr <= '0;
      sr_q     <= '0;
      ena_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      bit_q    <= bit_d;
      mem_addr <= addr_d;
      sr_q     <= sr_d;
      ena_q    <= ena;
    end
  end

  // Next-state and datapath sequencing
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    addr_d  = mem_addr;
    sr_d    = sr_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = FETCH;
          addr_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        state_d = SHIFT;
        sr_d    = {mem_addr, mem_data};
        ph_d    = '0;
        bit_d   = '0;
      end
      SHIFT: begin
        if (ph_q == P_LAST) begin
          ph_d = '0;
          if (bit_q == 3'd7) begin
            state_d = GAP;
          end else begin
            bit_d = bit_q + 3'd1;
            sr_d  = {sr_q[6:0], 1'b0};
          end
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      GAP: begin
        if (ph_q == P_LAST) begin
          ph_d = '0;
          if (mem_addr == LAST_ADDR) begin
            state_d = DONE;
          end else begin
            state_d = FETCH;
            addr_d  = mem_addr + 4'd1;
          end
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values derived from the upcoming state so the outputs can be registered
  always_comb begin
    busy_d    = (state_d == FETCH) || (state_d == LOAD) ||
                (state_d == SHIFT) || (state_d == GAP);
    done_d    = (state_d == DONE);
    tx_sync_d = (state_d == SHIFT);
    tx_clk_d  = (state_d == SHIFT) && (ph_d >= P_HIGH);
    tx_data_d = (state_d == SHIFT) && sr_d[7];
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      tx_clk  <= 1'b0;
      tx_sync <= 1'b0;
      tx_data <= 1'b0;
    end else begin
      busy    <= busy_d;
      done    <= done_d;
      tx_clk  <= tx_clk_d;
      tx_sync <= tx_sync_d;
      tx_data <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_serial_sweep_sequencer.sv
// Directed bench for serial_sweep_sequencer: link decoder monitor plus
// hand-computed frame table for memory word[k] = ~k.
module tb_serial_sweep_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [3:0] mem_addr;
  logic [3:0] mem_data = 4'h0;
  logic       busy, done, tx_clk, tx_sync, tx_data;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_tab [16] = '{8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A, 8'h69, 8'h78,
                               8'h87, 8'h96, 8'hA5, 8'hB4, 8'hC3, 8'hD2, 8'hE1, 8'hF0};

  always #5 clk = ~clk;

  serial_sweep_sequencer #(.CLK_DIV(2), .LAST_ADDR(4'd15)) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .busy     (busy),
    .done     (done),
    .tx_clk   (tx_clk),
    .tx_sync  (tx_sync),
    .tx_data  (tx_data)
  );

  // synchronous memory, one cycle read latency, word[k] = ~k
  always @(posedge clk) mem_data <= ~mem_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // link monitor, sampled 1 time unit after each rising edge
  logic       mon_clr = 1'b0;
  int         ncyc = 0, busy_cnt = 0, done_cnt = 0, rise_cnt = 0, sync_cnt = 0;
  int         bad_edge = 0, busy_rise_cyc = 0, first_sync_d = -1, done_dly = 0;
  int         gap_run = 0, gap_min = 999, gap_max = 0, nbits = 0;
  logic       seen_frame = 1'b0;
  logic [7:0] shf = '0;
  logic [7:0] frames [$];
  logic       p_busy = 1'b0, p_clk = 1'b0, p_sync = 1'b0, p_data = 1'b0;

  always @(posedge clk) begin
    #1;
    ncyc++;
    if (mon_clr) begin
      busy_cnt = 0; done_cnt = 0; rise_cnt = 0; sync_cnt = 0; bad_edge = 0;
      first_sync_d = -1; done_dly = 0; gap_run = 0; gap_min = 999; gap_max = 0;
      nbits = 0; seen_frame = 1'b0; frames.delete();
    end else begin
      if (busy && !p_busy) begin
        busy_rise_cyc = ncyc;
        first_sync_d  = -1;
        seen_frame    = 1'b0;
        gap_run       = 0;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_dly = ncyc - busy_rise_cyc;
      end
      if (tx_sync) begin
        sync_cnt++;
        if (!p_sync) begin
          if (first_sync_d < 0) first_sync_d = ncyc - busy_rise_cyc;
          if (seen_frame) begin
            if (gap_run < gap_min) gap_min = gap_run;
            if (gap_run > gap_max) gap_max = gap_run;
          end
        end
        gap_run = 0;
      end else if (busy) begin
        gap_run++;
      end
      if (tx_clk && !p_clk && tx_sync) begin
        rise_cnt++;
        shf = {shf[6:0], tx_data};
        nbits++;
        if (nbits == 8) begin
          frames.push_back(shf);
          nbits = 0;
          seen_frame = 1'b1;
        end
      end
      if (tx_clk && p_clk && (tx_data !== p_data)) bad_edge++;
    end
    p_busy = busy; p_clk = tx_clk; p_sync = tx_sync; p_data = tx_data;
  end

  task automatic wait_done(input string tag, input int lim);
    int n = 0;
    while (done !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_frames(input string tag, input int cnt, input int lim);
    int n = 0;
    while (frames.size() < cnt && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(tag, (frames.size() >= cnt) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // clears the monitor, then raises ena for len cycles
  task automatic start_pulse(input int len);
    @(negedge clk); mon_clr = 1'b1; ena = 1'b0;
    @(negedge clk); mon_clr = 1'b0; ena = 1'b1;
    repeat (len) @(negedge clk);
    ena = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with ena high: outputs zero, no sweep afterwards
    rst = 1'b1; ena = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_outputs", {23'd0, mem_addr, busy, done, tx_clk, tx_sync, tx_data}, 32'd0);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("held_ena_outputs", {23'd0, mem_addr, busy, done, tx_clk, tx_sync, tx_data}, 32'd0);
    check("held_ena_busy_cnt", busy_cnt, 32'd0);

    // full sweep
    start_pulse(3);
    wait_done("sweep_done", 700);
    repeat (5) @(negedge clk);
    check("sweep_busy_len", busy_cnt, 32'd608);
    check("sweep_done_cnt", done_cnt, 32'd1);
    check("sweep_done_time", done_dly, 32'd608);
    check("first_bit_latency", first_sync_d, 32'd2);
    check("frame_count", frames.size(), 32'd16);
    for (int i = 0; i < 16 && i < frames.size(); i++)
      check($sformatf("frame_%0d", i), {24'd0, frames[i]}, {24'd0, exp_tab[i]});
    check("tx_clk_rises", rise_cnt, 32'd128);
    check("sync_cycles", sync_cnt, 32'd512);
    check("data_change_high", bad_edge, 32'd0);
    check("gap_min", gap_min, 32'd6);
    check("gap_max", gap_max, 32'd6);
    check("addr_hold_last", {28'd0, mem_addr}, 32'd15);
    check("idle_after_done", {31'd0, busy}, 32'd0);

    // ena held high: exactly one sweep
    @(negedge clk); mon_clr = 1'b1; ena = 1'b0;
    @(negedge clk); mon_clr = 1'b0; ena = 1'b1;
    wait_done("held_done", 700);
    repeat (700) @(negedge clk);
    check("held_done_cnt", done_cnt, 32'd1);
    check("held_busy_len", busy_cnt, 32'd608);
    ena = 1'b0;
    @(negedge clk); ena = 1'b1;
    repeat (3) @(negedge clk);
    check("restart_busy", {31'd0, busy}, 32'd1);
    check("restart_addr", {28'd0, mem_addr}, 32'd0);
    wait_done("restart_done", 700);
    repeat (3) @(negedge clk);
    check("restart_done_cnt", done_cnt, 32'd2);
    ena = 1'b0;

    // start edge during frame 7 is ignored
    start_pulse(2);
    wait_frames("reach_frame7", 7, 400);
    repeat (10) @(negedge clk);
    check("in_frame7", {31'd0, tx_sync}, 32'd1);
    ena = 1'b1;
    repeat (2) @(negedge clk);
    ena = 1'b0;
    wait_done("retrig_done", 700);
    repeat (5) @(negedge clk);
    check("retrig_busy_len", busy_cnt, 32'd608);
    check("retrig_done_cnt", done_cnt, 32'd1);
    check("retrig_frames", frames.size(), 32'd16);
    if (frames.size() > 7) check("retrig_frame7", {24'd0, frames[7]}, 32'h78);

    // reset during frame 3
    start_pulse(2);
    wait_frames("reach_frame3", 3, 200);
    repeat (10) @(negedge clk);
    check("in_frame3", {31'd0, tx_sync}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_sync", {31'd0, tx_sync}, 32'd0);
    check("midrst_clk", {31'd0, tx_clk}, 32'd0);
    check("midrst_addr", {28'd0, mem_addr}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    repeat (20) @(negedge clk);
    check("midrst_no_done", done_cnt, 32'd0);
    start_pulse(2);
    wait_frames("after_rst_frames", 2, 200);
    if (frames.size() > 1) begin
      check("after_rst_frame0", {24'd0, frames[0]}, 32'h0F);
      check("after_rst_frame1", {24'd0, frames[1]}, 32'h1E);
    end
    wait_done("after_rst_done", 700);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
